// File: rtl/cpu_bus_rx_pkg.sv
// Shared types and defaults for the NES CPU bus receiver and the mapper hub.
package cpu_bus_rx_pkg;

  typedef enum logic [1:0] {
    CPU_IDLE  = 2'd0,
    CPU_PHASE = 2'd1,
    CPU_HOLD  = 2'd2
  } cpu_state_e;

  localparam int WE_DLY_DEF  = 4;
  localparam int IDLE_TO_DEF = 96;
  localparam int SYNC_W      = 26;

  typedef struct packed {
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dat;
    logic        cpu_we;
    logic        cpu_oe;
    logic        m2_rise;
    logic        m2_fall;
    logic        cpu_halt;
  } map_in_t;

  typedef struct packed {
    logic [7:0] cpu_dout;
    logic       cpu_doe;
    logic       irq_n;
  } map_out_t;

endpackage

// File: rtl/cpu_bus_rx_sync2.sv
// Parameterised-width two-flop synchroniser with async active-low reset.
module cpu_bus_rx_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cpu_bus_rx.sv
// NES CPU cartridge bus receiver: synchronises the raw bus and emits per-cycle
// write/read events, M2 edge pulses and an M2-idle halt flag.
//   CPU_IDLE  | waiting for an armed M2 rise
//   CPU_PHASE | counting system clocks towards the sample point
//   CPU_HOLD  | sample taken, waiting for M2 fall
module cpu_bus_rx
  import cpu_bus_rx_pkg::*;
#(
  parameter int WE_DLY  = WE_DLY_DEF,
  parameter int IDLE_TO = IDLE_TO_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m2_i,
  input  logic        cpu_rw_i,
  input  logic        cpu_romsel_n_i,
  input  logic [14:0] cpu_addr_i,
  input  logic [7:0]  cpu_dat_i,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_dat_o,
  output logic        bus_we_o,
  output logic        bus_oe_o,
  output logic        m2_rise_o,
  output logic        m2_fall_o,
  output logic        cpu_halt_o
);

  logic [SYNC_W-1:0] sync_w;
  logic              m2_s, rw_s, romsel_n_s;
  logic [14:0]       addr_s;
  logic [7:0]        dat_s;

  cpu_bus_rx_sync2 #(.W(SYNC_W)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({m2_i, cpu_rw_i, cpu_romsel_n_i, cpu_addr_i, cpu_dat_i}),
    .q_o   (sync_w)
  );

  assign m2_s       = sync_w[25];
  assign rw_s       = sync_w[24];
  assign romsel_n_s = sync_w[23];
  assign addr_s     = sync_w[22:8];
  assign dat_s      = sync_w[7:0];

  cpu_state_e  state_q, state_d;
  logic [3:0]  phase_cnt_q, phase_cnt_d;
  logic [7:0]  idle_cnt_q, idle_cnt_d;
  logic [1:0]  fill_q, fill_d;
  logic        m2_d_q;
  logic        armed_q, armed_d;
  logic        rise_q, rise_d, fall_q, fall_d;
  logic        we_q, we_d, oe_q, oe_d, halt_q, halt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dat_q, dat_d;
  logic        sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CPU_IDLE;
      phase_cnt_q <= '0;
      idle_cnt_q  <= '0;
      fill_q      <= '0;
      m2_d_q      <= 1'b0;
      armed_q     <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      halt_q      <= 1'b1;
      addr_q      <= '0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      fill_q      <= fill_d;
      m2_d_q      <= m2_s;
      armed_q     <= armed_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      halt_q      <= halt_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
    end
  end

  always_comb begin
    // The synchroniser only reflects the pin after two clocks out of reset, so
    // arming waits for it to fill and then for M2 to be seen low once.
    fill_d      = {fill_q[0], 1'b1};
    armed_d     = armed_q | (fill_q[1] & ~m2_s);
    rise_d      = armed_q & m2_s & ~m2_d_q;
    fall_d      = m2_d_q & ~m2_s;
    idle_cnt_d  = rise_d ? 8'd0 : ((idle_cnt_q == 8'hFF) ? 8'hFF : idle_cnt_q + 8'd1);
    halt_d      = ~rise_d & (halt_q | (idle_cnt_d == 8'(IDLE_TO)));
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    we_d        = 1'b0;
    oe_d        = oe_q;
    addr_d      = addr_q;
    dat_d       = dat_q;
    sample      = 1'b0;

    case (state_q)
      CPU_IDLE: begin
        if (rise_q) begin
          phase_cnt_d = 4'd1;
          state_d     = CPU_PHASE;
          sample      = (WE_DLY == 1) & m2_s;
        end
      end
      CPU_PHASE: begin
        phase_cnt_d = phase_cnt_q + 4'd1;
        // Requiring M2 still high at the sample point rejects runt phases.
        if (fall_d) begin
          state_d = CPU_IDLE;
        end else if (m2_s && ({1'b0, phase_cnt_q} + 5'd1 == 5'(WE_DLY))) begin
          sample = 1'b1;
        end
      end
      CPU_HOLD: begin
        if (fall_d) begin
          oe_d    = 1'b0;
          state_d = CPU_IDLE;
        end
      end
      default: state_d = CPU_IDLE;
    endcase

    if (sample) begin
      state_d = CPU_HOLD;
      addr_d  = {~romsel_n_s, addr_s};
      dat_d   = dat_s;
      we_d    = ~rw_s;
      oe_d    = rw_s;
    end
  end

  assign bus_addr_o = addr_q;
  assign bus_dat_o  = dat_q;
  assign bus_we_o   = we_q;
  assign bus_oe_o   = oe_q;
  assign m2_rise_o  = rise_q;
  assign m2_fall_o  = fall_q;
  assign cpu_halt_o = halt_q;

endmodule

// File: tb/tb_cpu_bus_rx.sv
// Directed bench for cpu_bus_rx with a scoreboard of expected bus events.
module tb_cpu_bus_rx;
  import cpu_bus_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, m2_i, cpu_rw_i, cpu_romsel_n_i;
  logic [14:0] cpu_addr_i;
  logic [7:0]  cpu_dat_i;
  logic [15:0] bus_addr_o;
  logic [7:0]  bus_dat_o;
  logic        bus_we_o, bus_oe_o, m2_rise_o, m2_fall_o, cpu_halt_o;

  always #10 clk = ~clk;

  cpu_bus_rx #(.WE_DLY(WE_DLY_DEF), .IDLE_TO(IDLE_TO_DEF)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m2_i           (m2_i),
    .cpu_rw_i       (cpu_rw_i),
    .cpu_romsel_n_i (cpu_romsel_n_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_dat_i      (cpu_dat_i),
    .bus_addr_o     (bus_addr_o),
    .bus_dat_o      (bus_dat_o),
    .bus_we_o       (bus_we_o),
    .bus_oe_o       (bus_oe_o),
    .m2_rise_o      (m2_rise_o),
    .m2_fall_o      (m2_fall_o),
    .cpu_halt_o     (cpu_halt_o)
  );

  typedef struct packed {
    logic        is_wr;
    logic [15:0] addr;
    logic [7:0]  dat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_pass = 0;
  int   n_total = 0;
  int   rise_at, we_at, oe_at, fall_at, halt_up_at, we_cnt, rise_cnt, oe_cyc;
  logic halt_at_rise, halt_pre;
  logic oe_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (bus_we_o || (bus_oe_o && !oe_prev)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_event", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("mon_we_vs_oe", bus_we_o, e.is_wr);
        check("mon_addr", bus_addr_o, e.addr);
        if (e.is_wr) check("mon_dat", bus_dat_o, e.dat);
      end
    end
    if (m2_fall_o) check("oe_low_at_fall", bus_oe_o, 0);
    oe_prev = bus_oe_o;
  end

  task automatic observe(input int k);
    if (m2_rise_o) begin
      rise_cnt++;
      if (rise_at < 0) begin
        rise_at      = k;
        halt_at_rise = cpu_halt_o;
      end
    end
    if (bus_we_o) begin
      we_cnt++;
      if (we_at < 0) we_at = k;
    end
    if (bus_oe_o) begin
      oe_cyc++;
      if (oe_at < 0) oe_at = k;
    end
    if (m2_fall_o && fall_at < 0) fall_at = k;
    if (k == 2) halt_pre = cpu_halt_o;
    if (cpu_halt_o && halt_up_at < 0 && rise_at > 0) halt_up_at = k;
  endtask

  task automatic clear_obs();
    rise_at = -1; we_at = -1; oe_at = -1; fall_at = -1; halt_up_at = -1;
    we_cnt = 0; rise_cnt = 0; oe_cyc = 0; halt_at_rise = 1'bx; halt_pre = 1'bx;
  endtask

  // Raw M2 high for hi clocks then low for lo clocks; k counts edges since the raw rise.
  task automatic bus_cycle(input logic rw, input logic rs_n, input logic [14:0] a,
                           input logic [7:0] d, input int hi, input int lo);
    clear_obs();
    cpu_rw_i = rw; cpu_romsel_n_i = rs_n; cpu_addr_i = a; cpu_dat_i = d; m2_i = 1'b1;
    for (int k = 1; k <= hi + lo; k++) begin
      @(posedge clk); #1;
      observe(k);
      if (k == hi) m2_i = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_addr"}, bus_addr_o, 0);
    check({pfx, "_dat"},  bus_dat_o, 0);
    check({pfx, "_we"},   bus_we_o, 0);
    check({pfx, "_oe"},   bus_oe_o, 0);
    check({pfx, "_rise"}, m2_rise_o, 0);
    check({pfx, "_fall"}, m2_fall_o, 0);
    check({pfx, "_halt"}, cpu_halt_o, 1);
  endtask

  initial begin
    rst_n = 1'b0; m2_i = 1'b0; cpu_rw_i = 1'b1; cpu_romsel_n_i = 1'b1;
    cpu_addr_i = '0; cpu_dat_i = '0;
    repeat (2) @(posedge clk); #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("post_rst_halt", cpu_halt_o, 1);

    // Basic write: strobe 3 + 4 clocks after raw M2 rise.
    sb.push_back('{1'b1, 16'h9000, 8'h5A});
    bus_cycle(1'b0, 1'b0, 15'h1000, 8'h5A, 17, 11);
    check("wr_rise_at", rise_at, 3);
    check("wr_we_at", we_at, 7);
    check("wr_we_cnt", we_cnt, 1);
    check("wr_rise_cnt", rise_cnt, 1);
    check("wr_fall_at", fall_at, 20);
    check("wr_halt_at_rise", halt_at_rise, 0);

    // Read: oe from sample point until the fall cycle, no strobe.
    sb.push_back('{1'b0, 16'h6123, 8'h00});
    bus_cycle(1'b1, 1'b1, 15'h6123, 8'hC3, 17, 11);
    check("rd_we_cnt", we_cnt, 0);
    check("rd_oe_at", oe_at, 7);
    check("rd_oe_cycles", oe_cyc, 13);
    check("rd_fall_at", fall_at, 20);

    // Shortest high phase that still strobes: WE_DLY + 1.
    sb.push_back('{1'b1, 16'h8ABC, 8'h3C});
    bus_cycle(1'b0, 1'b0, 15'h0ABC, 8'h3C, 5, 12);
    check("hi5_we_cnt", we_cnt, 1);
    check("hi5_we_at", we_at, 7);

    // Runts: no strobe, latched values kept.
    bus_cycle(1'b0, 1'b0, 15'h0222, 8'h11, 3, 12);
    check("runt3_we_cnt", we_cnt, 0);
    check("runt3_rise_cnt", rise_cnt, 1);
    check("runt3_addr", bus_addr_o, 16'h8ABC);
    check("runt3_dat", bus_dat_o, 8'h3C);
    bus_cycle(1'b0, 1'b0, 15'h0333, 8'h22, 4, 12);
    check("runt4_we_cnt", we_cnt, 0);
    check("runt4_addr", bus_addr_o, 16'h8ABC);

    // Idle timeout: halt rises 96 clocks after the rise cycle.
    sb.push_back('{1'b1, 16'h8155, 8'hA5});
    bus_cycle(1'b0, 1'b0, 15'h0155, 8'hA5, 17, 110);
    check("idle_halt_at_rise", halt_at_rise, 0);
    check("idle_halt_up_at", halt_up_at, 3 + IDLE_TO_DEF);
    sb.push_back('{1'b1, 16'h4321, 8'h99});
    bus_cycle(1'b0, 1'b1, 15'h4321, 8'h99, 17, 11);
    check("wake_halt_before", halt_pre, 1);
    check("wake_halt_at_rise", halt_at_rise, 0);
    check("wake_we_cnt", we_cnt, 1);

    // M2 already high at reset release must not produce an edge.
    m2_i = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    clear_obs();
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      observe(k);
      if (k == 10) m2_i = 1'b0;
    end
    check("hirel_rise_cnt", rise_cnt, 0);
    check("hirel_we_cnt", we_cnt, 0);
    sb.push_back('{1'b1, 16'h8456, 8'h6E});
    bus_cycle(1'b0, 1'b0, 15'h0456, 8'h6E, 17, 11);
    check("hirel_wr_we_cnt", we_cnt, 1);
    check("hirel_wr_rise_at", rise_at, 3);

    // Reset pulsed mid-PHASE of a write.
    clear_obs();
    cpu_rw_i = 1'b0; cpu_romsel_n_i = 1'b0; cpu_addr_i = 15'h0777; cpu_dat_i = 8'h77;
    m2_i = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("midrst_addr_before", bus_addr_o, 16'h8456);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      observe(k);
      if (k == 8) m2_i = 1'b0;
    end
    check("midrst_we_cnt", we_cnt, 0);
    check("midrst_addr_after", bus_addr_o, 0);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu_bus_rx.md
# cpu_bus_rx

Front-end receiver for the NES CPU cartridge bus: synchronises M2, R/W, /ROMSEL, address and data into the system clock domain and emits clean per-cycle events (write strobe, read enable, M2 edges, CPU-halt flag). These events are what every mapper core consumes. It feeds the CPU-side fields of `MapIn` ahead of the mapper hub, which is the opposite direction from the hub's `MapOut` path back to the bus.

## Interface
- `WE_DLY`, 4: system-clock cycles after the synchronised M2 rise at which address/data are sampled and `bus_we` fires. Legal range 1..15.
- `IDLE_TO`, 96: system-clock cycles without an M2 rise before `cpu_halt` asserts. Legal range 2..255.
- `clk` in 1: system clock, nominally 50 MHz. It is the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `m2` in 1: raw CPU M2 (phi2).
- `cpu_rw` in 1: raw R/W; 1 = read.
- `cpu_romsel_n` in 1: raw /ROMSEL.
- `cpu_addr` in 15: raw A14..A0.
- `cpu_dat` in 8: raw data bus, sampled for writes only.
- `bus_addr` out 16: latched address; bit 15 = !romsel_n.
- `bus_dat` out 8: latched write data.
- `bus_we` out 1: one-cycle pulse per completed CPU write.
- `bus_oe` out 1: high from sample point to the M2 fall on read cycles.
- `m2_rise`, `m2_fall` out 1: one-cycle edge pulses.
- `cpu_halt` out 1: level; M2 idle timeout, meaning CPU reset or power-down.

## Operation
- All raw inputs pass through a 2-flop synchroniser. `m2_d` holds the previous synchronised M2. Edges are decoded from the synchronised M2 and `m2_d`.
- The FSM has three states: IDLE, PHASE, HOLD.
  - IDLE: on `m2_rise`, load phase counter to 1 and go to PHASE.
  - PHASE: the counter increments each cycle. When the counter equals `WE_DLY`, latch `bus_addr`/`bus_dat` from the synchronised bus, then go to HOLD.
    - If synchronised rw = 0: `bus_we` = 1 for that single cycle.
    - If synchronised rw = 1: set `bus_oe`.
  - HOLD: wait; on `m2_fall`, clear `bus_oe` and go to IDLE.
  - M2 fall while in PHASE (glitch or runt): abort to IDLE. No strobe; latched outputs unchanged.
- Idle counter: 8-bit, saturating. Cleared on `m2_rise`, otherwise increments.
  - `cpu_halt` sets when the count reaches `IDLE_TO`.
  - `cpu_halt` clears in the same cycle as the next `m2_rise`.
- Exactly one `bus_we` per M2 high phase, never more.
- `bus_addr`/`bus_dat` hold their value until the next sample point.
- Reset values: `bus_addr` = 0, `bus_dat` = 0, `bus_we` = 0, `bus_oe` = 0, `m2_rise` = 0, `m2_fall` = 0, `cpu_halt` = 1 (the CPU is considered halted until the first M2 rise). FSM = IDLE; counters and synchroniser flops = 0.

## Timing
- The raw M2 edge to the `m2_rise`/`m2_fall` pulse takes 3 clk: 2 synchroniser flops plus the edge register.
- `bus_we` asserts `WE_DLY` cycles after `m2_rise`, inclusive of the cycle after `m2_rise`. It stays high exactly 1 cycle.
- `bus_addr`/`bus_dat` are valid in the same cycle as `bus_we`/`bus_oe` rise.
- `bus_oe` falls in the `m2_fall` cycle.
- An M2 high phase shorter than `WE_DLY` + 1 synchronised cycles produces no strobe.
- Simultaneous `m2_rise` and idle count = `IDLE_TO`: the rise wins. The counter clears and `cpu_halt` = 0.
- Reset asserted mid-PHASE: outputs go to their reset values immediately. A pending strobe is dropped.
- After reset release, the first `bus_we` requires a full fresh M2 rise. An M2 that is already high at release does not generate an edge until it falls and rises again, because `m2_d` resets to 0 while the synchroniser reads 1. This produces a false rise, so IDLE additionally requires synchronised M2 = 0 once before arming. An `armed` flag is cleared on reset.

## Structure
- Shared package: the FSM state enum (`CPU_IDLE`, `CPU_PHASE`, `CPU_HOLD`) and default constants for `WE_DLY`/`IDLE_TO`, alongside `MapIn`/`MapOut`.
- Natural sub-module: `sync2`, a parameterised-width 2-flop synchroniser with async active-low reset. It is instantiated once for the 26-bit bundle {m2, rw, romsel_n, addr, dat}.

## Test plan
- Write: 1.79 MHz M2, rw = 0, romsel_n = 0, addr = 0x1000, dat = 0x5A. Required: one `bus_we`, `bus_addr` = 0x9000, `bus_dat` = 0x5A, 3 + 4 clk after the raw M2 rise.
- Read: rw = 1, romsel_n = 1, addr = 0x6123. Required: `bus_we` stays 0, `bus_oe` high from the sample point to `m2_fall`, `bus_addr` = 0x6123.
- Runt M2 high of 3 clk with `WE_DLY` = 4 on a write. Required: no `bus_we`; `bus_addr`/`bus_dat` keep their previous values.
- Idle: hold M2 low for 96 clk. Required: `cpu_halt` rises at count 96. The next M2 rise clears it in the `m2_rise` cycle, and that cycle's write still strobes.
- M2 high at reset release: no `m2_rise` and no strobe until M2 falls and rises again. The subsequent write strobes normally.
- `rst_n` pulsed low during PHASE of a write. Required: all outputs reach their reset values asynchronously, and no `bus_we` occurs for that cycle.
